// File: rtl/pmcc_wait_sequencer.sv
// -----------------------------------------------------------------------------
// pmcc_wait_sequencer
//
// Wait engine for the PMC coprocessor. Executes fixed cycle delays, waits for
// a trigger level or rising edge (with optional timeout), and waits for a
// number of trigger rising edges. While an operation runs, 'waiting' stalls
// the coprocessor; completion is a one-cycle 'done' pulse, and a timeout on
// LEVEL/EDGE waits sets the sticky 'timed_out' flag.
//
// Ports:
//   clk        in   core clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle request, accepted only in IDLE
//   mode       in   00 DELAY, 01 LEVEL, 10 EDGE, 11 EDGE_COUNT
//   count      in   delay / timeout (0 = none) / edge count, sampled with start
//   trigger    in   external trigger, synchronous to clk
//   abort      in   cancels an operation in progress
//   waiting    out  high while not IDLE
//   done       out  one-cycle completion pulse
//   timed_out  out  sticky timeout flag
//   dbg_state  out  current FSM state encoding, for observation
//
// Handshake: start is a single-cycle request with no ready; it is consumed
// only when the engine is IDLE and abort is low, otherwise it is dropped.
// -----------------------------------------------------------------------------
module pmcc_wait_sequencer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [CNT_WIDTH-1:0] count,
  input  logic                 trigger,
  input  logic                 abort,
  output logic                 waiting,
  output logic                 done,
  output logic                 timed_out,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_LEVEL = 3'd2,
    S_EDGE  = 3'd3,
    S_ECNT  = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_to_en;
  logic                 r_trig_q;
  logic                 r_done;
  logic                 r_timed_out;

  logic                 w_rise;
  logic                 w_done_nxt;
  logic                 w_to_set;
  logic                 w_to_clr;
  logic                 w_cnt_load;
  logic                 w_cnt_dec;
  logic                 w_last;

  assign w_rise = trigger & ~r_trig_q;
  assign w_last = (r_cnt == CNT_ONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath control
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_to_set    = 1'b0;
    w_to_clr    = 1'b0;
    w_cnt_load  = 1'b0;
    w_cnt_dec   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_cnt_load = 1'b1;
          w_to_clr   = 1'b1;
          case (mode)
            2'b00: begin
              if (count == '0) w_done_nxt  = 1'b1;
              else             w_state_nxt = S_DELAY;
            end
            2'b01: w_state_nxt = S_LEVEL;
            2'b10: w_state_nxt = S_EDGE;
            default: begin
              if (count == '0) w_done_nxt  = 1'b1;
              else             w_state_nxt = S_ECNT;
            end
          endcase
        end
      end
      S_DELAY: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_to_clr    = 1'b1;
        end else begin
          w_cnt_dec = 1'b1;
          if (w_last) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      S_LEVEL, S_EDGE: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_to_clr    = 1'b1;
        end else if ((r_state == S_LEVEL) ? trigger : w_rise) begin
          // Condition beats a same-cycle timeout.
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else if (r_to_en) begin
          w_cnt_dec = 1'b1;
          if (w_last) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
            w_to_set    = 1'b1;
          end
        end
      end
      S_ECNT: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_to_clr    = 1'b1;
        end else if (w_rise) begin
          w_cnt_dec = 1'b1;
          if (w_last) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_to_en     <= 1'b0;
      r_trig_q    <= 1'b0;
      r_done      <= 1'b0;
      r_timed_out <= 1'b0;
    end else begin
      r_trig_q <= trigger;
      r_done   <= w_done_nxt;
      if (w_cnt_load) begin
        r_cnt   <= count;
        r_to_en <= (count != '0);
      end else if (w_cnt_dec && (r_cnt != '0)) begin
        // Guarded so the counter can never wrap below zero.
        r_cnt <= r_cnt - CNT_ONE;
      end
      if (w_to_clr) begin
        r_timed_out <= 1'b0;
      end else if (w_to_set) begin
        r_timed_out <= 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    waiting   = (r_state != S_IDLE);
    dbg_state = r_state;
  end

  assign done      = r_done;
  assign timed_out = r_timed_out;

endmodule

// File: tb/tb_pmcc_wait_sequencer.sv
// -----------------------------------------------------------------------------
// Directed testbench for pmcc_wait_sequencer. Inputs are applied 1 ns after a
// rising edge ("cycle c" begins at that edge); outputs are sampled on the
// falling edge of the same cycle. Expected values are hand-derived per cycle.
// -----------------------------------------------------------------------------
module tb_pmcc_wait_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] count = '0;
  logic         trigger = 1'b0;
  logic         abort = 1'b0;
  logic         waiting;
  logic         done;
  logic         timed_out;
  logic [2:0]   dbg_state;

  int n_vec = 0;
  int n_err = 0;

  pmcc_wait_sequencer #(.CNT_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .count     (count),
    .trigger   (trigger),
    .abort     (abort),
    .waiting   (waiting),
    .done      (done),
    .timed_out (timed_out),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver tasks
  task automatic drive(input logic s, input logic [1:0] m, input logic [W-1:0] c,
                       input logic t, input logic a);
    @(posedge clk);
    #1;
    start = s; mode = m; count = c; trigger = t; abort = a;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00, '0, 1'b0, 1'b0);
  endtask

  // Tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (waiting !== 1'b0 || done !== 1'b0 || timed_out !== 1'b0 || dbg_state !== 3'd0) begin
      n_err++;
      $display("FAIL reset: got w=%b d=%b to=%b st=%0d, want 0 0 0 0",
               waiting, done, timed_out, dbg_state);
    end
    #1 rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_delay();
    logic ew, ed;
    // DELAY 3: waiting in 1..3, done in 4.
    for (int c = 0; c <= 6; c++) begin
      drive(c == 0, 2'b00, 16'd3, 1'b0, 1'b0);
      @(negedge clk);
      ew = (c >= 1 && c <= 3);
      ed = (c == 4);
      n_vec++;
      if (waiting !== ew || done !== ed || timed_out !== 1'b0) begin
        n_err++;
        $display("FAIL delay3 c=%0d: got w=%b d=%b to=%b, want %b %b 0",
                 c, waiting, done, timed_out, ew, ed);
      end
    end
    idle(2);
    // DELAY 0: done in cycle 1, never waiting.
    for (int c = 0; c <= 3; c++) begin
      drive(c == 0, 2'b00, 16'd0, 1'b0, 1'b0);
      @(negedge clk);
      ed = (c == 1);
      n_vec++;
      if (waiting !== 1'b0 || done !== ed) begin
        n_err++;
        $display("FAIL delay0 c=%0d: got w=%b d=%b, want 0 %b", c, waiting, done, ed);
      end
    end
    idle(2);
  endtask

  task automatic test_level();
    logic ew, ed, et;
    // LEVEL no timeout, trigger already high: waiting in 1, done in 2.
    for (int c = 0; c <= 4; c++) begin
      drive(c == 0, 2'b01, 16'd0, 1'b1, 1'b0);
      @(negedge clk);
      ew = (c == 1);
      ed = (c == 2);
      n_vec++;
      if (waiting !== ew || done !== ed || timed_out !== 1'b0) begin
        n_err++;
        $display("FAIL level_hi c=%0d: got w=%b d=%b to=%b, want %b %b 0",
                 c, waiting, done, timed_out, ew, ed);
      end
    end
    idle(2);
    // LEVEL timeout 5, trigger low: done+timed_out in 6, flag sticks.
    for (int c = 0; c <= 8; c++) begin
      drive(c == 0, 2'b01, 16'd5, 1'b0, 1'b0);
      @(negedge clk);
      ew = (c >= 1 && c <= 5);
      ed = (c == 6);
      et = (c >= 6);
      n_vec++;
      if (waiting !== ew || done !== ed || timed_out !== et) begin
        n_err++;
        $display("FAIL level_to c=%0d: got w=%b d=%b to=%b, want %b %b %b",
                 c, waiting, done, timed_out, ew, ed, et);
      end
    end
    // Trigger arrives in the timeout cycle: condition wins; new start clears flag.
    for (int c = 0; c <= 8; c++) begin
      drive(c == 0, 2'b01, 16'd5, c == 5, 1'b0);
      @(negedge clk);
      ew = (c >= 1 && c <= 5);
      ed = (c == 6);
      et = (c == 0);
      n_vec++;
      if (waiting !== ew || done !== ed || timed_out !== et) begin
        n_err++;
        $display("FAIL level_race c=%0d: got w=%b d=%b to=%b, want %b %b %b",
                 c, waiting, done, timed_out, ew, ed, et);
      end
    end
    idle(2);
    // LEVEL timeout 1 boundary: waiting in 1 only, done+timed_out in 2.
    for (int c = 0; c <= 3; c++) begin
      drive(c == 0, 2'b01, 16'd1, 1'b0, 1'b0);
      @(negedge clk);
      ew = (c == 1);
      ed = (c == 2);
      et = (c >= 2);
      n_vec++;
      if (waiting !== ew || done !== ed || timed_out !== et) begin
        n_err++;
        $display("FAIL level_to1 c=%0d: got w=%b d=%b to=%b, want %b %b %b",
                 c, waiting, done, timed_out, ew, ed, et);
      end
    end
    idle(2);
  endtask

  task automatic test_edge();
    logic ew, ed, et, t;
    // EDGE no timeout: trigger high 0..9 gives no rise; low 10..11, high 12 -> done 13.
    for (int c = 0; c <= 15; c++) begin
      t = (c <= 9) || (c >= 12);
      drive(c == 0, 2'b10, 16'd0, t, 1'b0);
      @(negedge clk);
      ew = (c >= 1 && c <= 12);
      ed = (c == 13);
      et = (c == 0);   // left over from the previous LEVEL timeout
      n_vec++;
      if (waiting !== ew || done !== ed || timed_out !== et) begin
        n_err++;
        $display("FAIL edge c=%0d: got w=%b d=%b to=%b, want %b %b %b",
                 c, waiting, done, timed_out, ew, ed, et);
      end
    end
    idle(2);
    // EDGE timeout 3 with trigger held high (no rise): done+timed_out in 4.
    for (int c = 0; c <= 5; c++) begin
      drive(c == 0, 2'b10, 16'd3, 1'b1, 1'b0);
      @(negedge clk);
      ew = (c >= 1 && c <= 3);
      ed = (c == 4);
      et = (c >= 4);
      n_vec++;
      if (waiting !== ew || done !== ed || timed_out !== et) begin
        n_err++;
        $display("FAIL edge_to c=%0d: got w=%b d=%b to=%b, want %b %b %b",
                 c, waiting, done, timed_out, ew, ed, et);
      end
    end
    idle(2);
  endtask

  task automatic test_edge_count();
    logic ew, ed, t;
    // ECNT 3, pulses at 2,5,8, stray DELAY-1 start at 4 ignored -> done 9.
    for (int c = 0; c <= 11; c++) begin
      t = (c == 2) || (c == 5) || (c == 8);
      drive(c == 0 || c == 4, (c == 4) ? 2'b00 : 2'b11, (c == 4) ? 16'd1 : 16'd3, t, 1'b0);
      @(negedge clk);
      ew = (c >= 1 && c <= 8);
      ed = (c == 9);
      n_vec++;
      if (waiting !== ew || done !== ed || timed_out !== (c == 0)) begin
        n_err++;
        $display("FAIL ecnt c=%0d: got w=%b d=%b to=%b, want %b %b %b",
                 c, waiting, done, timed_out, ew, ed, (c == 0));
      end
    end
    idle(2);
    // Same run, abort in cycle 6 (and a pulse at 8 after abort): idle from 7, no done.
    for (int c = 0; c <= 11; c++) begin
      t = (c == 2) || (c == 5) || (c == 8);
      drive(c == 0, 2'b11, 16'd3, t, c == 6);
      @(negedge clk);
      ew = (c >= 1 && c <= 6);
      n_vec++;
      if (waiting !== ew || done !== 1'b0 || timed_out !== 1'b0) begin
        n_err++;
        $display("FAIL ecnt_abort c=%0d: got w=%b d=%b to=%b, want %b 0 0",
                 c, waiting, done, timed_out, ew);
      end
    end
    idle(2);
    // ECNT 0: immediate done in cycle 1, never waiting.
    for (int c = 0; c <= 2; c++) begin
      drive(c == 0, 2'b11, 16'd0, 1'b0, 1'b0);
      @(negedge clk);
      n_vec++;
      if (waiting !== 1'b0 || done !== (c == 1)) begin
        n_err++;
        $display("FAIL ecnt0 c=%0d: got w=%b d=%b, want 0 %b", c, waiting, done, (c == 1));
      end
    end
    idle(2);
  endtask

  task automatic test_abort_start();
    // start together with abort in IDLE is ignored.
    for (int c = 0; c <= 3; c++) begin
      drive(c == 0, 2'b00, 16'd2, 1'b0, c == 0);
      @(negedge clk);
      n_vec++;
      if (waiting !== 1'b0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL abort_start c=%0d: got w=%b d=%b, want 0 0", c, waiting, done);
      end
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic ew, ed;
    // DELAY 2 at 0 (done 3), DELAY 1 started at 3 (waiting 4, done 5).
    for (int c = 0; c <= 7; c++) begin
      drive(c == 0 || c == 3, 2'b00, (c == 3) ? 16'd1 : 16'd2, 1'b0, 1'b0);
      @(negedge clk);
      ew = (c >= 1 && c <= 2) || (c == 4);
      ed = (c == 3) || (c == 5);
      n_vec++;
      if (waiting !== ew || done !== ed) begin
        n_err++;
        $display("FAIL b2b c=%0d: got w=%b d=%b, want %b %b", c, waiting, done, ew, ed);
      end
    end
    idle(2);
    // Zero-count starts in cycles 0 and 1 -> done in 1 and 2.
    for (int c = 0; c <= 4; c++) begin
      drive(c <= 1, 2'b00, 16'd0, 1'b0, 1'b0);
      @(negedge clk);
      ed = (c == 1) || (c == 2);
      n_vec++;
      if (waiting !== 1'b0 || done !== ed) begin
        n_err++;
        $display("FAIL b2b_zero c=%0d: got w=%b d=%b, want 0 %b", c, waiting, done, ed);
      end
    end
    idle(2);
  endtask

  task automatic test_reset_mid_op();
    logic ew;
    // DELAY 10, reset low during cycles 3..4, released in 5; nothing afterwards.
    for (int c = 0; c <= 15; c++) begin
      drive(c == 0, 2'b00, 16'd10, 1'b0, 1'b0);
      if (c == 3) rst_n = 1'b0;
      if (c == 5) rst_n = 1'b1;
      @(negedge clk);
      ew = (c >= 1 && c <= 2);
      n_vec++;
      if (waiting !== ew || done !== 1'b0 || timed_out !== 1'b0) begin
        n_err++;
        $display("FAIL rst_mid c=%0d: got w=%b d=%b to=%b, want %b 0 0",
                 c, waiting, done, timed_out, ew);
      end
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_delay();
    test_level();
    test_edge();
    test_edge_count();
    test_abort_start();
    test_back_to_back();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
